// File: rtl/cmp_bmp_loader_if.sv
// Bitmap-loader bundle: control, memory read port, cmpacc bitmap/result port.
// master = loader side, slave = processor/memory/cmpacc side.
interface cmp_bmp_loader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BMP_W  = 1536,
  parameter int unsigned ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic [BMP_W-1:0]  bmp_out;
  logic              bmp_wren;
  logic              acc_done;
  logic [15:0]       acc_result;
  logic [15:0]       result;
  logic              result_valid;
  logic              err;

  modport master (
    input  start, base_addr, mem_rdata, mem_rvalid, acc_done, acc_result,
    output busy, mem_rd, mem_addr, bmp_out, bmp_wren, result, result_valid, err
  );

  modport slave (
    output start, base_addr, mem_rdata, mem_rvalid, acc_done, acc_result,
    input  busy, mem_rd, mem_addr, bmp_out, bmp_wren, result, result_valid, err
  );
endinterface

// File: rtl/cmp_bmp_loader.sv
// Fetches a BMP_W bitmap word by word, hands it to cmpacc and returns its result.
// Optional RUN watchdog enabled by defining CMP_BMP_LOADER_TIMEOUT_EN.
module cmp_bmp_loader #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned BMP_W       = 1536,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic               clk,
  input logic               rst_n,
  cmp_bmp_loader_if.master  bus
);

  localparam int unsigned NWORDS = BMP_W / WORD_W;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  if ((BMP_W % WORD_W) != 0 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("cmp_bmp_loader: WORD_W must divide BMP_W and TIMEOUT_CYC must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_base;
  logic              r_busy;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BMP_W-1:0]  r_bmp;
  logic              r_wren;
  logic [15:0]       r_result;
  logic              r_rv;

  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;

`ifdef CMP_BMP_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;
`endif

  assign w_last      = (r_cnt == CNT_W'(NWORDS - 1));
  // Address arithmetic wraps modulo 2^ADDR_W on purpose.
  assign w_next_addr = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);

  // Sequencer: one read outstanding, then one wren pulse, then wait for cmpacc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_busy     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_bmp      <= '0;
      r_wren     <= 1'b0;
      r_result   <= '0;
      r_rv       <= 1'b0;
`ifdef CMP_BMP_LOADER_TIMEOUT_EN
      r_tmo      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_mem_rd <= 1'b0;
      r_wren   <= 1'b0;
      r_rv     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base     <= bus.base_addr;
            r_cnt      <= '0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= bus.base_addr;
            r_busy     <= 1'b1;
            r_state    <= S_FETCH;
`ifdef CMP_BMP_LOADER_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            r_bmp[WORD_W*32'(r_cnt) +: WORD_W] <= bus.mem_rdata;
            if (w_last) begin
              r_wren  <= 1'b1;
              r_state <= S_LOAD;
            end else begin
              r_cnt      <= r_cnt + CNT_W'(1);
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_next_addr;
              r_state    <= S_FETCH;
            end
          end
        end
        S_LOAD: begin
          r_state <= S_RUN;
`ifdef CMP_BMP_LOADER_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        S_RUN: begin
          // acc_done takes priority over an expiring watchdog.
          if (bus.acc_done) begin
            r_result <= bus.acc_result;
            r_rv     <= 1'b1;
            r_state  <= S_DONE;
          end
`ifdef CMP_BMP_LOADER_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_result <= 16'hFFFF;
            r_err    <= 1'b1;
            r_rv     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.bmp_out      = r_bmp;
  assign bus.bmp_wren     = r_wren;
  assign bus.result       = r_result;
  assign bus.result_valid = r_rv;
`ifdef CMP_BMP_LOADER_TIMEOUT_EN
  assign bus.err          = r_err;
`else
  assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_cmp_bmp_loader.sv
// Randomized bench for cmp_bmp_loader with a memory responder and a word-list reference model.
// Timeout cases run only when CMP_BMP_LOADER_TIMEOUT_EN is defined (TIMEOUT_CYC=16 here).
module tb_cmp_bmp_loader;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BMP_W       = 1536;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned NWORDS      = BMP_W / WORD_W;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_bmp_loader_if #(.WORD_W(WORD_W), .BMP_W(BMP_W), .ADDR_W(ADDR_W)) bus ();

  cmp_bmp_loader #(
    .WORD_W(WORD_W), .BMP_W(BMP_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [0:65535];
  int n_total = 0;
  int n_bad   = 0;
  int lat_mode = 0;              // 0: 1-cycle, 1: 1..8 cycles random, 2: fixed 4 cycles
  int n_rd, n_wren, n_rv, n_overlap;
  logic [15:0] rd_addr_q[$];
  logic [15:0] m_addr;
  int m_d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd) begin
        n_rd++;
        rd_addr_q.push_back(bus.mem_addr);
      end
      if (bus.bmp_wren) n_wren++;
      if (bus.result_valid) n_rv++;
    end
  end

  // Memory responder; flags any new mem_rd while a read is still pending
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      while (bus.mem_rd) begin
        m_addr = bus.mem_addr;
        m_d = (lat_mode == 0) ? 0 : (lat_mode == 1) ? int'($urandom_range(0, 7)) : 3;
        @(posedge clk); #1;
        if (bus.mem_rd) n_overlap++;
        repeat (m_d) begin
          @(posedge clk); #1;
          if (bus.mem_rd) n_overlap++;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem[m_addr];
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
    end
  end

  task automatic run_op(input logic [15:0] base, input int n_wait, input logic [15:0] ares,
                        input bit expect_tmo, input bit busy_start, input bit check_lat);
    int  cyc;
    int  k;
    int  addr_bad;
    bit  ok;
    logic [15:0] exp_res;
    n_rd = 0; n_wren = 0; n_rv = 0; n_overlap = 0;
    rd_addr_q.delete();
    @(negedge clk);
    bus.base_addr = base;
    bus.start     = 1'b1;
    cyc = 0;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.base_addr = 16'($urandom);
    cyc = 1;
    check("busy_after_start", bus.busy, 1);
    check("err_clr_on_start", bus.err, 0);
    ok = 0;
    while (!ok && cyc < 3000) begin
      if (bus.bmp_wren) ok = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("wren_seen", ok, 1);
    if (!ok) return;
    if (check_lat) check("load_cycle", cyc, 2 * NWORDS + 1);
    for (int i = 0; i < int'(NWORDS); i++)
      check($sformatf("bmp_w%0d", i), bus.bmp_out[WORD_W*i +: WORD_W], mem[16'(base + 16'(i))]);
    k = 0;
    ok = 0;
    while (!ok && k < int'(TIMEOUT_CYC) + 40) begin
      @(negedge clk);
      cyc++;
      k++;
      bus.start = busy_start && (k == 1);
      if (busy_start && k == 1) bus.base_addr = base ^ 16'h5555;
      bus.acc_done   = !expect_tmo && (k == n_wait + 1);
      bus.acc_result = bus.acc_done ? ares : 16'($urandom);
      if (bus.result_valid) ok = 1;
    end
    bus.acc_done = 1'b0;
    check("rv_seen", ok, 1);
    if (!ok) return;
    exp_res = expect_tmo ? 16'hFFFF : ares;
    check("result", bus.result, exp_res);
    check("err", bus.err, expect_tmo);
    check("busy_in_done", bus.busy, 1);
    if (expect_tmo) check("tmo_run_cycles", k, TIMEOUT_CYC + 1);
    else if (check_lat) check("start_to_rv", cyc, 2 * NWORDS + 3 + n_wait);
    // start during DONE must be dropped
    bus.start     = 1'b1;
    bus.base_addr = 16'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_idle", bus.busy, 0);
    check("rv_one_cycle", bus.result_valid, 0);
    @(negedge clk);
    check("done_start_ignored", bus.busy, 0);
    check("result_hold", bus.result, exp_res);
    check("err_hold", bus.err, expect_tmo);
    check("n_mem_rd", n_rd, NWORDS);
    check("n_wren", n_wren, 1);
    check("n_rv", n_rv, 1);
    check("overlap", n_overlap, 0);
    addr_bad = 0;
    for (int i = 0; i < rd_addr_q.size(); i++)
      if (rd_addr_q[i] !== 16'(base + 16'(i))) addr_bad++;
    check("addr_seq", addr_bad, 0);
  endtask

  task automatic reset_mid_fetch(input logic [15:0] base);
    int w;
    int guard;
    lat_mode = 2;
    @(negedge clk);
    bus.base_addr = base;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    guard = 0;
    while (w < 11 && guard < 500) begin
      if (bus.mem_rd) w++;
      if (w < 11) @(negedge clk);
      guard++;
    end
    check("reach_word10", w, 11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_rd", bus.mem_rd, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wren", bus.bmp_wren, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    check("rst_bmp_nz", |bus.bmp_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_rd = 0;
    repeat (20) @(negedge clk);
    check("no_rd_after_rst", n_rd, 0);
    check("idle_after_rst", bus.busy, 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.acc_done   = 1'b0;
    bus.acc_result = '0;
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    repeat (3) @(negedge clk);
    check("init_busy", bus.busy, 0);
    check("init_mem_rd", bus.mem_rd, 0);
    check("init_result", bus.result, 0);
    check("init_rv", bus.result_valid, 0);
    check("init_err", bus.err, 0);
    check("init_bmp_nz", |bus.bmp_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal load with the documented pattern
    for (int i = 0; i < int'(NWORDS); i++) mem[16'h0100 + i] = 32'hA500_0000 | 32'(i);
    lat_mode = 0;
    run_op(16'h0100, 5, 16'h002A, 0, 0, 1);
    check("bmp_lo", bus.bmp_out[31:0], 32'hA500_0000);
    check("bmp_hi", bus.bmp_out[1535:1504], 32'hA500_002F);

    // Variable memory latency, same bitmap
    lat_mode = 1;
    run_op(16'h0100, 3, 16'h1234, 0, 0, 0);

    // Address wrap
    lat_mode = 0;
    run_op(16'hFFF0, 0, 16'hBEEF, 0, 0, 1);

    // start while busy is not queued
    run_op(16'h0100, 4, 16'h0F0F, 0, 1, 1);
    run_op(16'h0100, 1, 16'h7777, 0, 0, 1);

    reset_mid_fetch(16'h2000);

    for (int t = 0; t < 6; t++) begin
      lat_mode = int'($urandom_range(0, 1));
      run_op(16'($urandom), int'($urandom_range(0, 12)), 16'($urandom_range(1, 16'hFFFE)),
             0, 0, lat_mode == 0);
    end

`ifdef CMP_BMP_LOADER_TIMEOUT_EN
    lat_mode = 0;
    run_op(16'h0300, 0, 16'h0000, 1, 0, 1);
    run_op(16'h0300, 2, 16'h4242, 0, 0, 1);
    run_op(16'h0400, TIMEOUT_CYC - 1, 16'h5A5A, 0, 0, 1);
`else
    lat_mode = 0;
    run_op(16'h0300, 30, 16'h4242, 0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
